// File: rtl/text_pkg.sv
// Shared types and constants for the text-mode character pipeline.
package text_pkg;

   localparam int COLS     = 80;
   localparam int ROWS     = 30;
   localparam int CELL_W   = 8;
   localparam int CELL_H   = 16;
   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;

   typedef logic [11:0] rgb12_t;

   // One VRAM word: invert flag, glyph code, foreground and background palette indices.
   typedef struct packed {
      logic       invert;
      logic [6:0] code;
      logic [3:0] fg_idx;
      logic [3:0] bg_idx;
   } cell_t;

   // Coordinates and sync signals travelling alongside the pixel data.
   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       hs;
      logic       vs;
      logic       de;
   } timing_t;

   // row*80 + col built from shifts; worst case 31*80+127 = 2607 fits in 12 bits.
   function automatic logic [11:0] cell_addr(input logic [4:0] row, input logic [6:0] col);
      logic [11:0] row_w;
      row_w = {7'd0, row};
      return (row_w << 6) + (row_w << 4) + {5'd0, col};
   endfunction

   // Reset contents of palette entry i: grey level i on all three channels.
   function automatic rgb12_t pal_ramp(input logic [3:0] idx);
      return {idx, idx, idx};
   endfunction

endpackage

// File: rtl/text_palette.sv
// 16-entry RGB 4:4:4 palette: one write port, two combinational read ports,
// grey-ramp contents after reset. A read racing a write to the same entry
// returns the old value because the array only changes at the clock edge.
module text_palette
   import text_pkg::*;
(
   input  logic       pixel_clk,
   input  logic       reset,
   input  logic       we,
   input  logic [3:0] waddr,
   input  rgb12_t     wdata,
   input  logic [3:0] raddr_a,
   input  logic [3:0] raddr_b,
   output rgb12_t     rdata_a,
   output rgb12_t     rdata_b
);

   rgb12_t entry_r [16];

   // Palette storage: restore the ramp on reset, otherwise accept writes.
   always_ff @(posedge pixel_clk) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) begin
            entry_r[i] <= pal_ramp(4'(i));
         end
      end else if (we) begin
         entry_r[waddr] <= wdata;
      end
   end

   assign rdata_a = entry_r[raddr_a];
   assign rdata_b = entry_r[raddr_b];

endmodule

// File: rtl/text_cell_fetch.sv
// Character-cell fetch: turns a pixel coordinate into a VRAM cell address,
// resolves the returned cell through the palette, overlays a blinking cursor
// and delays coordinates/syncs so every output lines up with its pixel.
// Stage 1 = address register, stage 2 = the VRAM's own read register,
// stage 3 = output register.
module text_cell_fetch
   import text_pkg::*;
#(
   parameter int BLINK_FRAMES = 30
)(
   input  logic        pixel_clk,
   input  logic        reset,
   input  logic [9:0]  drawX,
   input  logic [9:0]  drawY,
   input  logic        hsync,
   input  logic        vsync,
   input  logic        vde,
   output logic [11:0] vram_addr,
   input  logic [15:0] vram_rdata,
   input  logic        pal_we,
   input  logic [3:0]  pal_addr,
   input  logic [11:0] pal_wdata,
   input  logic        cursor_en,
   input  logic [6:0]  cursor_col,
   input  logic [4:0]  cursor_row,
   output logic [6:0]  pix_code,
   output logic        invert,
   output logic [11:0] fg,
   output logic [11:0] bg,
   output logic [9:0]  drawX_d,
   output logic [9:0]  drawY_d,
   output logic        hsync_d,
   output logic        vsync_d,
   output logic        vde_d
);

   localparam int LATENCY = 3;
   localparam int CNT_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

   timing_t          tim_r [LATENCY];
   logic [11:0]      vram_addr_r;
   logic [6:0]       cur_col_r;
   logic [4:0]       cur_row_r;
   logic             cur_en_r;
   logic             active_r;
   logic             cursor_on_r;
   logic [CNT_W-1:0] frame_cnt_r;
   logic             blink_on_r;
   logic [6:0]       pix_code_r;
   logic             invert_r;
   rgb12_t           fg_r;
   rgb12_t           bg_r;

   logic             frame_start_s;
   logic             active_s;
   logic             hit_s;
   cell_t            cell_s;
   rgb12_t           pal_fg_s;
   rgb12_t           pal_bg_s;
   logic [6:0]       nxt_code_s;
   logic             nxt_invert_s;
   rgb12_t           nxt_fg_s;
   rgb12_t           nxt_bg_s;

   assign frame_start_s = (drawX == 10'd0) && (drawY == 10'd0);
   assign cell_s        = cell_t'(vram_rdata);
   assign active_s      = (tim_r[0].x < 10'(H_ACTIVE)) && (tim_r[0].y < 10'(V_ACTIVE));
   assign hit_s         = (tim_r[0].x[9:3] == cur_col_r) && (tim_r[0].y[8:4] == cur_row_r);

   text_palette u_palette (
      .pixel_clk (pixel_clk),
      .reset     (reset),
      .we        (pal_we),
      .waddr     (pal_addr),
      .wdata     (pal_wdata),
      .raddr_a   (cell_s.fg_idx),
      .raddr_b   (cell_s.bg_idx),
      .rdata_a   (pal_fg_s),
      .rdata_b   (pal_bg_s)
   );

   // Coordinate/sync delay line, one entry per pipeline stage.
   always_ff @(posedge pixel_clk) begin
      if (reset) begin
         for (int i = 0; i < LATENCY; i++) begin
            tim_r[i] <= '0;
         end
      end else begin
         tim_r[0] <= '{x: drawX, y: drawY, hs: hsync, vs: vsync, de: vde};
         for (int i = 1; i < LATENCY; i++) begin
            tim_r[i] <= tim_r[i-1];
         end
      end
   end

   // Stage 1: cell address and cursor controls captured with the coordinate.
   always_ff @(posedge pixel_clk) begin
      if (reset) begin
         vram_addr_r <= 12'd0;
         cur_col_r   <= 7'd0;
         cur_row_r   <= 5'd0;
         cur_en_r    <= 1'b0;
      end else begin
         vram_addr_r <= cell_addr(drawY[8:4], drawX[9:3]);
         cur_col_r   <= cursor_col;
         cur_row_r   <= cursor_row;
         cur_en_r    <= cursor_en;
      end
   end

   // Stage 2: active-area and cursor flags, arriving together with the VRAM word.
   always_ff @(posedge pixel_clk) begin
      if (reset) begin
         active_r    <= 1'b0;
         cursor_on_r <= 1'b0;
      end else begin
         active_r    <= active_s;
         cursor_on_r <= hit_s & cur_en_r;
      end
   end

   // Blink phase: counts frame starts and flips blink_on every BLINK_FRAMES frames.
   always_ff @(posedge pixel_clk) begin
      if (reset) begin
         frame_cnt_r <= '0;
         blink_on_r  <= 1'b1;
      end else if (frame_start_s) begin
         if (frame_cnt_r == CNT_LAST) begin
            frame_cnt_r <= '0;
            blink_on_r  <= ~blink_on_r;
         end else begin
            frame_cnt_r <= frame_cnt_r + 1'b1;
         end
      end
   end

   // Stage-3 next values: palette lookup and cursor overlay, blanked outside the active area.
   always_comb begin
      nxt_code_s   = 7'd0;
      nxt_invert_s = 1'b0;
      nxt_fg_s     = 12'h000;
      nxt_bg_s     = 12'h000;
      if (active_r) begin
         nxt_code_s   = cell_s.code;
         nxt_invert_s = cell_s.invert ^ (cursor_on_r & blink_on_r);
         nxt_fg_s     = pal_fg_s;
         nxt_bg_s     = pal_bg_s;
      end else begin
         nxt_code_s   = 7'd0;
         nxt_invert_s = 1'b0;
         nxt_fg_s     = 12'h000;
         nxt_bg_s     = 12'h000;
      end
   end

   // Stage 3: output register feeding the colour mapper.
   always_ff @(posedge pixel_clk) begin
      if (reset) begin
         pix_code_r <= 7'd0;
         invert_r   <= 1'b0;
         fg_r       <= 12'h000;
         bg_r       <= 12'h000;
      end else begin
         pix_code_r <= nxt_code_s;
         invert_r   <= nxt_invert_s;
         fg_r       <= nxt_fg_s;
         bg_r       <= nxt_bg_s;
      end
   end

   assign vram_addr = vram_addr_r;
   assign pix_code  = pix_code_r;
   assign invert    = invert_r;
   assign fg        = fg_r;
   assign bg        = bg_r;
   assign drawX_d   = tim_r[LATENCY-1].x;
   assign drawY_d   = tim_r[LATENCY-1].y;
   assign hsync_d   = tim_r[LATENCY-1].hs;
   assign vsync_d   = tim_r[LATENCY-1].vs;
   assign vde_d     = tim_r[LATENCY-1].de;

endmodule

// File: tb/tb_text_cell_fetch.sv
// Self-checking bench for text_cell_fetch: table of pixel vectors streamed
// back to back, plus hand sequences for palette hazard, reset and cursor blink.
module tb_text_cell_fetch;

   logic        pixel_clk = 1'b0;
   logic        reset;
   logic [9:0]  drawX, drawY;
   logic        hsync, vsync, vde;
   logic [11:0] vram_addr;
   logic [15:0] vram_rdata;
   logic        pal_we;
   logic [3:0]  pal_addr;
   logic [11:0] pal_wdata;
   logic        cursor_en;
   logic [6:0]  cursor_col;
   logic [4:0]  cursor_row;
   logic [6:0]  pix_code;
   logic        invert;
   logic [11:0] fg, bg;
   logic [9:0]  drawX_d, drawY_d;
   logic        hsync_d, vsync_d, vde_d;

   logic [15:0] mem [4096];

   int total = 0;
   int bad   = 0;

   always #5 pixel_clk = ~pixel_clk;

   text_cell_fetch #(.BLINK_FRAMES(2)) dut (
      .pixel_clk (pixel_clk), .reset (reset),
      .drawX (drawX), .drawY (drawY),
      .hsync (hsync), .vsync (vsync), .vde (vde),
      .vram_addr (vram_addr), .vram_rdata (vram_rdata),
      .pal_we (pal_we), .pal_addr (pal_addr), .pal_wdata (pal_wdata),
      .cursor_en (cursor_en), .cursor_col (cursor_col), .cursor_row (cursor_row),
      .pix_code (pix_code), .invert (invert), .fg (fg), .bg (bg),
      .drawX_d (drawX_d), .drawY_d (drawY_d),
      .hsync_d (hsync_d), .vsync_d (vsync_d), .vde_d (vde_d)
   );

   // VRAM model: synchronous read, data valid one cycle after the address.
   always_ff @(posedge pixel_clk) begin
      vram_rdata <= mem[vram_addr];
   end

   typedef struct {
      logic [9:0]  x;
      logic [9:0]  y;
      logic        hs;
      logic        vs;
      logic        de;
      logic [11:0] addr;
      logic [6:0]  code;
      logic        inv;
      logic [11:0] fgc;
      logic [11:0] bgc;
   } vec_t;

   localparam int NV = 8;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge pixel_clk);
      #1;
   endtask

   task automatic drive(input logic [9:0] x, input logic [9:0] y,
                        input logic hs, input logic vs, input logic de);
      drawX = x; drawY = y; hsync = hs; vsync = vs; vde = de;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_addr"},  32'(vram_addr), 32'd0);
      check({tag, "_code"},  32'(pix_code),  32'd0);
      check({tag, "_inv"},   32'(invert),    32'd0);
      check({tag, "_fg"},    32'(fg),        32'd0);
      check({tag, "_bg"},    32'(bg),        32'd0);
      check({tag, "_xd"},    32'(drawX_d),   32'd0);
      check({tag, "_yd"},    32'(drawY_d),   32'd0);
      check({tag, "_hsd"},   32'(hsync_d),   32'd0);
      check({tag, "_vsd"},   32'(vsync_d),   32'd0);
      check({tag, "_vded"},  32'(vde_d),     32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic exp_blink [5];
      exp_blink = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

      for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
      mem[165]  = 16'h8A3C;   // row 2 col 5
      mem[567]  = 16'hFFFF;   // blanking cell (700,100)
      mem[2399] = 16'h0512;   // last visible cell
      mem[0]    = 16'h7FF0;   // cell (0,0)
      mem[81]   = 16'hC145;   // cell (1,1)
      mem[972]  = 16'h2A9E;   // cell (12,12)
      mem[2401] = 16'hFFFF;   // row 30, below active area

      //          x     y     hs    vs    de    addr      code   inv   fg       bg
      vecs[0] = '{10'd40,  10'd32,  1'b1, 1'b0, 1'b1, 12'd165,  7'h0A, 1'b1, 12'h333, 12'hCCC};
      vecs[1] = '{10'd700, 10'd100, 1'b0, 1'b0, 1'b0, 12'd567,  7'h00, 1'b0, 12'h000, 12'h000};
      vecs[2] = '{10'd639, 10'd479, 1'b1, 1'b1, 1'b1, 12'd2399, 7'h05, 1'b0, 12'h111, 12'h222};
      vecs[3] = '{10'd0,   10'd0,   1'b0, 1'b1, 1'b1, 12'd0,    7'h7F, 1'b0, 12'hFFF, 12'h000};
      vecs[4] = '{10'd7,   10'd15,  1'b1, 1'b1, 1'b0, 12'd0,    7'h7F, 1'b0, 12'hFFF, 12'h000};
      vecs[5] = '{10'd8,   10'd16,  1'b0, 1'b0, 1'b1, 12'd81,   7'h41, 1'b1, 12'h444, 12'h555};
      vecs[6] = '{10'd100, 10'd200, 1'b1, 1'b0, 1'b1, 12'd972,  7'h2A, 1'b0, 12'h999, 12'hEEE};
      vecs[7] = '{10'd10,  10'd480, 1'b0, 1'b1, 1'b0, 12'd2401, 7'h00, 1'b0, 12'h000, 12'h000};

      reset = 1'b1;
      pal_we = 1'b0; pal_addr = 4'd0; pal_wdata = 12'h000;
      cursor_en = 1'b0; cursor_col = 7'd0; cursor_row = 5'd0;
      drive(10'd40, 10'd32, 1'b1, 1'b1, 1'b1);
      step(); step(); step();
      check_all_zero("reset");

      // Streamed table: address one cycle after input, outputs three cycles after.
      reset = 1'b0;
      for (int i = 0; i < NV + 2; i++) begin
         if (i < NV) drive(vecs[i].x, vecs[i].y, vecs[i].hs, vecs[i].vs, vecs[i].de);
         else        drive(10'd700, 10'd100, 1'b0, 1'b0, 1'b0);
         step();
         if (i < NV) check($sformatf("addr_v%0d", i), 32'(vram_addr), 32'(vecs[i].addr));
         if (i >= 2) begin
            check($sformatf("code_v%0d", i-2), 32'(pix_code), 32'(vecs[i-2].code));
            check($sformatf("inv_v%0d",  i-2), 32'(invert),   32'(vecs[i-2].inv));
            check($sformatf("fg_v%0d",   i-2), 32'(fg),       32'(vecs[i-2].fgc));
            check($sformatf("bg_v%0d",   i-2), 32'(bg),       32'(vecs[i-2].bgc));
            check($sformatf("xd_v%0d",   i-2), 32'(drawX_d),  32'(vecs[i-2].x));
            check($sformatf("yd_v%0d",   i-2), 32'(drawY_d),  32'(vecs[i-2].y));
            check($sformatf("hsd_v%0d",  i-2), 32'(hsync_d),  32'(vecs[i-2].hs));
            check($sformatf("vsd_v%0d",  i-2), 32'(vsync_d),  32'(vecs[i-2].vs));
            check($sformatf("vded_v%0d", i-2), 32'(vde_d),    32'(vecs[i-2].de));
         end
      end

      // Palette write racing a read of the same entry: old value first, new value next pixel.
      drive(10'd40, 10'd32, 1'b1, 1'b1, 1'b1); step();
      drive(10'd40, 10'd32, 1'b1, 1'b1, 1'b1); step();
      drive(10'd700, 10'd100, 1'b0, 1'b0, 1'b0);
      pal_we = 1'b1; pal_addr = 4'd3; pal_wdata = 12'hF00;
      step();
      pal_we = 1'b0;
      check("pal_old_fg", 32'(fg), 32'h333);
      step();
      check("pal_new_fg", 32'(fg), 32'hF00);
      check("pal_new_bg", 32'(bg), 32'hCCC);

      // One-cycle reset mid-line: everything clears on the next cycle, palette back to ramp.
      drive(10'd40, 10'd32, 1'b1, 1'b1, 1'b1); step();
      drive(10'd48, 10'd32, 1'b1, 1'b1, 1'b1);
      reset = 1'b1;
      step();
      check_all_zero("midrst");
      reset = 1'b0;
      drive(10'd40, 10'd32, 1'b1, 1'b1, 1'b1); step();
      step(); step();
      check("ramp_fg",   32'(fg),       32'h333);
      check("ramp_bg",   32'(bg),       32'hCCC);
      check("ramp_code", 32'(pix_code), 32'h0A);

      // Cursor blink with BLINK_FRAMES=2; frame 0 is the one in progress at reset.
      cursor_en = 1'b1; cursor_col = 7'd0; cursor_row = 5'd0;
      for (int f = 0; f < 5; f++) begin
         if (f == 0) drive(10'd4, 10'd4, 1'b0, 1'b0, 1'b1);
         else        drive(10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
         step();
         drive(10'd8, 10'd0, 1'b0, 1'b0, 1'b1); step();
         drive(10'd700, 10'd100, 1'b0, 1'b0, 1'b0); step();
         check($sformatf("blink_f%0d", f), 32'(invert), 32'(exp_blink[f]));
         drive(10'd700, 10'd100, 1'b0, 1'b0, 1'b0); step();
         check($sformatf("cell10_f%0d", f), 32'(invert), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
